// File: rtl/vga_timing_pkg.sv
// 800x600@72 timing defaults and derived constants, shared by the sync generator and pixel generator.
// Also holds the counter type and the delayed-flag bundle that travels down the sync pipe.
package vga_timing_pkg;

  localparam int CNT_W = 11;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int H_VISIBLE_DEF = 800;
  localparam int H_FRONT_DEF   = 56;
  localparam int H_SYNC_DEF    = 120;
  localparam int H_BACK_DEF    = 64;
  localparam int V_VISIBLE_DEF = 600;
  localparam int V_FRONT_DEF   = 37;
  localparam int V_SYNC_DEF    = 6;
  localparam int V_BACK_DEF    = 23;

  localparam int H_TOTAL_DEF      = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF      = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  function automatic logic in_range(input cnt_t c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) <= hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay for a WIDTH-bit bundle; latency DEPTH cycles.
// Free-running, no backpressure; all stages clear on reset.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             pixel_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counters plus sync/DE/RGB outputs; outputs lag hcnt/vcnt by 2 cycles.
// Free-running, no backpressure; pixel data is expected one cycle after its hcnt/vcnt.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE = H_VISIBLE_DEF,
  parameter int   H_FRONT   = H_FRONT_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BACK    = H_BACK_DEF,
  parameter int   V_VISIBLE = V_VISIBLE_DEF,
  parameter int   V_FRONT   = V_FRONT_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BACK    = V_BACK_DEF,
  parameter logic SYNC_POL  = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        rst,
  output logic [10:0] hcnt,
  output logic [10:0] vcnt,
  input  logic [2:0]  pixel_r_in,
  input  logic [2:0]  pixel_g_in,
  input  logic [2:0]  pixel_b_in,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [2:0]  vga_r,
  output logic [2:0]  vga_g,
  output logic [2:0]  vga_b,
  output logic        video_de,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SS    = H_VISIBLE + H_FRONT;
  localparam int V_SS    = V_VISIBLE + V_FRONT;

  logic  h_last, v_last;
  sync_t raw, d1, d2;

  assign h_last = (hcnt == cnt_t'(H_TOTAL - 1));
  assign v_last = (vcnt == cnt_t'(V_TOTAL - 1));

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      hcnt      <= '0;
      vcnt      <= '0;
      frame_cnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      if (v_last) begin
        vcnt      <= '0;
        frame_cnt <= frame_cnt + 8'd1;
      end else begin
        vcnt <= vcnt + 11'd1;
      end
    end else begin
      hcnt <= hcnt + 11'd1;
    end
  end

  // Derived from the counter registers, so it is high throughout reset as well.
  assign frame_start = (hcnt == '0) && (vcnt == '0);

  always_comb begin
    raw.de = (hcnt < cnt_t'(H_VISIBLE)) && (vcnt < cnt_t'(V_VISIBLE));
    raw.hs = in_range(hcnt, H_SS, H_SS + H_SYNC - 1);
    raw.vs = in_range(vcnt, V_SS, V_SS + V_SYNC - 1);
  end

  // Split into two single-stage lines so the middle DE tap can gate the RGB register.
  vga_delay_line #(.WIDTH(3), .DEPTH(1)) u_pipe_s1 (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .din       (raw),
    .dout      (d1)
  );

  vga_delay_line #(.WIDTH(3), .DEPTH(1)) u_pipe_s2 (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .din       (d1),
    .dout      (d2)
  );

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else begin
      vga_r <= d1.de ? pixel_r_in : 3'd0;
      vga_g <= d1.de ? pixel_g_in : 3'd0;
      vga_b <= d1.de ? pixel_b_in : 3'd0;
    end
  end

  assign video_de  = d2.de;
  assign vga_hsync = d2.hs ? SYNC_POL : ~SYNC_POL;
  assign vga_vsync = d2.vs ? SYNC_POL : ~SYNC_POL;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunken 20x10 raster; expectations come from modular arithmetic on the edge count.
module tb_vga_sync_gen;

  localparam int HV = 10, HF = 2, HS = 4, HB = 4;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        pixel_clk, rst;
  logic [10:0] hcnt, vcnt;
  logic [2:0]  pixel_r_in, pixel_g_in, pixel_b_in;
  logic        vga_hsync, vga_vsync, video_de, frame_start;
  logic [2:0]  vga_r, vga_g, vga_b;
  logic [7:0]  frame_cnt;

  int compared = 0;
  int mismatched = 0;
  int t = 0;
  logic [8:0] applied = '0;
  logic [8:0] cap = '0;
  bit hold7 = 0;

  vga_sync_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b1)
  ) dut (
    .pixel_clk(pixel_clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt),
    .pixel_r_in(pixel_r_in), .pixel_g_in(pixel_g_in), .pixel_b_in(pixel_b_in),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .video_de(video_de), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Expected outputs after t clock edges since reset release.
  task automatic check_model();
    int h, v, s, sh, sv;
    bit de, hs, vs;
    h = t % HT;
    v = (t / HT) % VT;
    s = t - 2;
    de = 0; hs = 0; vs = 0;
    if (s >= 0) begin
      sh = s % HT;
      sv = (s / HT) % VT;
      de = (sh < HV) && (sv < VV);
      hs = (sh >= HV + HF) && (sh < HV + HF + HS);
      vs = (sv >= VV + VF) && (sv < VV + VF + VS);
    end
    check("hcnt", 32'(hcnt), 32'(h));
    check("vcnt", 32'(vcnt), 32'(v));
    check("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));
    check("frame_cnt", 32'(frame_cnt), 32'((t / FRAME) % 256));
    check("video_de", 32'(video_de), 32'(de));
    check("vga_hsync", 32'(vga_hsync), 32'(hs));
    check("vga_vsync", 32'(vga_vsync), 32'(vs));
    check("vga_rgb", 32'({vga_r, vga_g, vga_b}), de ? 32'(cap) : 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_hcnt"}, 32'(hcnt), 32'd0);
    check({tag, "_vcnt"}, 32'(vcnt), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd1);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({tag, "_de"}, 32'(video_de), 32'd0);
    check({tag, "_hsync"}, 32'(vga_hsync), 32'd0);
    check({tag, "_vsync"}, 32'(vga_vsync), 32'd0);
    check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
  endtask

  task automatic step();
    @(posedge pixel_clk);
    t++;
    cap = applied;
    #1;
    applied = hold7 ? 9'o777 : 9'($urandom);
    {pixel_r_in, pixel_g_in, pixel_b_in} = applied;
    @(negedge pixel_clk);
    check_model();
  endtask

  initial begin
    int hs_cnt, vs_cnt, rgb7_cnt, bad_cnt;
    bit found;

    rst = 1'b0;
    applied = 9'($urandom);
    {pixel_r_in, pixel_g_in, pixel_b_in} = applied;
    repeat (10) @(posedge pixel_clk);
    @(negedge pixel_clk);
    check_reset_state("reset_hold");

    rst = 1'b1;
    t = 0;
    check_model();

    // Random pixels over three frames, including the line and frame wraps.
    repeat (3 * FRAME) step();

    // Constant full-scale pixels: count per-frame sync and visible cycles.
    hold7 = 1;
    repeat (2) step();
    hs_cnt = 0; vs_cnt = 0; rgb7_cnt = 0; bad_cnt = 0;
    repeat (FRAME) begin
      step();
      if (vga_hsync) hs_cnt++;
      if (vga_vsync) vs_cnt++;
      if ({vga_r, vga_g, vga_b} == 9'o777) begin
        rgb7_cnt++;
        if (!video_de) bad_cnt++;
      end else if ({vga_r, vga_g, vga_b} != 9'd0) begin
        bad_cnt++;
      end
    end
    check("hsync_cycles_per_frame", 32'(hs_cnt), 32'(HS * VT));
    check("vsync_cycles_per_frame", 32'(vs_cnt), 32'(VS * HT));
    check("visible_rgb_cycles", 32'(rgb7_cnt), 32'(HV * VV));
    check("rgb_outside_de", 32'(bad_cnt), 32'd0);
    hold7 = 0;

    // Asynchronous reset in the middle of the visible area.
    found = 0;
    for (int i = 0; i < FRAME && !found; i++) begin
      step();
      if ((t % HT) == 5 && ((t / HT) % VT) == 3) found = 1;
    end
    check("midframe_target_reached", 32'(found), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_state("midframe_async");
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    check_reset_state("midframe_hold");
    rst = 1'b1;
    t = 0;
    check_model();

    // Run 256 frames so frame_cnt passes 255 and wraps back to 0.
    repeat (256 * FRAME) step();
    check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
    check("frame_start_after_wrap", 32'(frame_start), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
